frame_stream_tx: RTL and testbench
==================================

# frame_stream_tx

- Frame-stream transmitter that drives the pixel-stream input of the team's 2D filters (sort/median, mean, morphology).
- Reads one stored frame from a synchronous frame-buffer read port and emits it as a raster stream (`vsync_out`, `dout_valid`, `dout`), with programmable vsync width, vertical blanking and horizontal blanking.
- Sits between the frame buffer and the first filter stage, and doubles as the stimulus source for filter benches.

## Interface
Parameters:
- `DW`, 14, pixel width
- `IW`, 640, pixels per line
- `IH`, 512, lines per frame
- `AW`, 19, frame-buffer address width (must hold IW*IH-1)
- `VS_LEN`, 4, vsync high cycles (≥1)
- `VB_LEN`, 16, vertical blanking cycles before the first line and after the last line (≥2)
- `HB_LEN`, 32, blanking cycles between lines (≥2)

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request one frame; sampled in IDLE only
- `cont`  in  1  continuous mode; sampled at end of frame
- `rd_en`  out  1  frame-buffer read strobe
- `rd_addr`  out  AW  frame-buffer read address
- `rd_data`  in  DW  read data, valid exactly 1 cycle after `rd_en`
- `pat_sel`  in  1  select test pattern (`FRAME_TX_TPG_EN` only)
- `vsync_out`  out  1  frame sync, active high
- `dout_valid`  out  1  pixel valid
- `dout`  out  DW  pixel
- `busy`  out  1  high whenever the FSM is not in IDLE
- `frame_done`  out  1  one-cycle pulse at end of frame

## Operation
- FSM states: IDLE, VSYNC, VB_PRE, LINE, HBLANK, VB_POST.
- Transitions:
  - IDLE → VSYNC on `start`=1.
  - VSYNC lasts VS_LEN cycles → VB_PRE.
  - VB_PRE lasts VB_LEN cycles → LINE.
  - LINE lasts IW cycles → HBLANK if line_cnt<IH-1, else VB_POST.
  - HBLANK lasts HB_LEN cycles → LINE with line_cnt+1.
  - VB_POST lasts VB_LEN cycles → VSYNC if `cont`=1 on its last cycle, else IDLE.
- `frame_done` pulses on the last VB_POST cycle, whether or not `cont` is set.
- Outputs per state:
  - `vsync_out`=1 only in VSYNC.
  - `rd_en`=1 only in LINE.
- Addressing: `rd_addr` is 0 on the first LINE cycle of each frame, increments by 1 per `rd_en`, and reaches IW*IH-1 on the last pixel. No wrap within a frame; it is reloaded to 0 on entry to VSYNC.
- Counters: pix_cnt 0..IW-1, line_cnt 0..IH-1, blank_cnt sized for max(VS_LEN, VB_LEN, HB_LEN). All are cleared on entry to VSYNC.
- Output pipeline: the `rd_en` pipe is delayed 1 cycle to qualify `rd_data`; `dout`/`dout_valid` are registered from it.
- `start` while `busy`=1 is ignored and not queued.
- `cont` dropped mid-frame: the current frame completes, then the FSM returns to IDLE.
- Reset mid-frame: all outputs drop immediately (asynchronous) and the FSM goes to IDLE. There is no partial-frame resume.
- Reset values: `vsync_out`=0, `dout_valid`=0, `dout`=0, `rd_en`=0, `rd_addr`=0, `busy`=0, `frame_done`=0.

## Timing
- `start` sampled high at edge T0 → `vsync_out`=1 in cycles T0+1 .. T0+VS_LEN.
- First `rd_en` in cycle T0+1+VS_LEN+VB_LEN.
- Pixel latency: `rd_en` in cycle t → `dout_valid`=1 with that pixel in cycle t+2.
- `dout_valid` occurs in bursts of exactly IW cycles, one burst per line.
- HB_LEN≥2 and VB_LEN≥2 guarantee:
  - each burst completes before the next `rd_en`;
  - the last pixel is out before `frame_done`.
- Frame period from `start` to `frame_done` pulse (inclusive): VS_LEN + 2*VB_LEN + IH*IW + (IH-1)*HB_LEN cycles.
- In continuous mode, VSYNC of the next frame starts the cycle after `frame_done`.

## Configuration
- `FRAME_TX_TPG_EN` defined:
  - `pat_sel`=1 replaces `rd_data` with the internal pattern `dout` = (pix_cnt + line_cnt) mod 2^DW, aligned to the same 2-cycle pipeline.
  - `rd_en` is still driven, so timing is identical.
  - `pat_sel` is sampled at VSYNC entry and held for the whole frame.
- Undefined: `pat_sel` is ignored (left unconnected internally) and `dout` always comes from `rd_data`.

## Structure
- Package `frame_tx_pkg`:
  - the state enum;
  - a clog2-style width function for blank_cnt/pix_cnt/line_cnt;
  - the elaboration-time check of the VB_LEN/HB_LEN ≥2 constraints.
- One sub-module: `frame_tx_tpg` (pattern generator with the 2-stage alignment), instantiated only under `FRAME_TX_TPG_EN`.
- FSM, counters and address generation stay in the top.

## Test plan
Common bench configuration: IW=4, IH=3, VS_LEN=2, VB_LEN=3, HB_LEN=2, frame buffer loaded with data = address.

1. Single frame:
   - `start` pulse → `vsync_out` high 2 cycles.
   - `dout` sequence 0..11 in three 4-cycle bursts, separated by 2 idle cycles.
   - `frame_done` exactly 24 cycles after `start` is sampled; `busy` low the cycle after.
2. Pixel latency: each `rd_addr` N issued in cycle t → `dout`=N with `dout_valid` in t+2. Last `rd_addr`=11.
3. Continuous mode:
   - `cont`=1 → second `vsync_out` rises the cycle after the first `frame_done`, and `rd_addr` restarts at 0.
   - Drop `cont` mid-frame 2 → exactly 2 frames, then IDLE.
4. `start` asserted during LINE of frame 1 → no extra frame and no counter disturbance.
5. `rst_n` low during line 1 → all outputs 0 asynchronously. Release + `start` → full frame from `rd_addr`=0.
6. With `FRAME_TX_TPG_EN` and `pat_sel`=1 → `dout` = 0,1,2,3 / 1,2,3,4 / 2,3,4,5 per line, with identical timing to scenario 1.

Source files
------------

// File: rtl/frame_tx_pkg.sv
// Shared types and elaboration helpers for the frame-stream transmitter.
// Optional feature macro used by the block: FRAME_TX_TPG_EN.
package frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VSYNC   = 3'd1,
    ST_VB_PRE  = 3'd2,
    ST_LINE    = 3'd3,
    ST_HBLANK  = 3'd4,
    ST_VB_POST = 3'd5
  } state_e;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Blanking must be long enough for the 2-cycle output pipe to drain
  // before the next read burst and before the end-of-frame pulse.
  function automatic bit blanking_ok(input int vs_len, input int vb_len, input int hb_len);
    return (vs_len >= 1) && (vb_len >= 2) && (hb_len >= 2);
  endfunction

  function automatic bit addr_fits(input int aw, input int iw, input int ih);
    return (64'(iw) * 64'(ih) - 64'd1) < (64'd1 << aw);
  endfunction

endpackage

// File: rtl/frame_tx_tpg.sv
// Test-pattern generator: pixel value = pix_cnt + line_cnt (mod 2^DW).
// Registers the pattern once so it lines up with synchronous read data;
// the transmitter's output register supplies the second pipeline stage.
// Only instantiated when FRAME_TX_TPG_EN is defined.
module frame_tx_tpg
  import frame_tx_pkg::*;
#(
  parameter int DW = 14,
  parameter int PW = 10,
  parameter int LW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [PW-1:0] pix_cnt,
  input  logic [LW-1:0] line_cnt,
  output logic [DW-1:0] pat_data
);

  localparam int SW = ((PW > LW) ? PW : LW) + 1;

  logic [SW-1:0] sum;
  logic [DW-1:0] pat_d, pat_q;

  // Pattern for the pixel addressed this cycle; held between reads.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    sum   = SW'(pix_cnt) + SW'(line_cnt);
    pat_d = pat_q;
    if (rd_en) pat_d = DW'(sum);
  end

  // Pattern register, aligned with the frame-buffer read latency.
  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pat_q <= '0;
    else        pat_q <= pat_d;
  end

  assign pat_data = pat_q;

endmodule

// File: rtl/frame_stream_tx.sv
// Frame-stream transmitter: reads one stored frame from a synchronous
// frame-buffer port and emits it as vsync / valid / pixel raster stream
// with programmable vsync width, vertical and horizontal blanking.
// Optional internal test pattern: define FRAME_TX_TPG_EN.
module frame_stream_tx
  import frame_tx_pkg::*;
#(
  parameter int DW     = 14,
  parameter int IW     = 640,
  parameter int IH     = 512,
  parameter int AW     = 19,
  parameter int VS_LEN = 4,
  parameter int VB_LEN = 16,
  parameter int HB_LEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cont,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  input  logic          pat_sel,
  output logic          vsync_out,
  output logic          dout_valid,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          frame_done
);

  localparam int PW = cnt_width(IW);
  localparam int LW = cnt_width(IH);
  localparam int BW = cnt_width(max3(VS_LEN, VB_LEN, HB_LEN));

  localparam logic [PW-1:0] PIX_LAST  = PW'(IW - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(IH - 1);
  localparam logic [BW-1:0] VS_LAST   = BW'(VS_LEN - 1);
  localparam logic [BW-1:0] VB_LAST   = BW'(VB_LEN - 1);
  localparam logic [BW-1:0] HB_LAST   = BW'(HB_LEN - 1);

  if (!blanking_ok(VS_LEN, VB_LEN, HB_LEN)) begin : g_bad_blanking
    $error("frame_stream_tx: needs VS_LEN>=1, VB_LEN>=2, HB_LEN>=2");
  end
  if (!addr_fits(AW, IW, IH)) begin : g_bad_aw
    $error("frame_stream_tx: AW too narrow for IW*IH-1");
  end

  state_e        state_d, state_q;
  logic [BW-1:0] blank_d, blank_q;
  logic [PW-1:0] pix_d, pix_q;
  logic [LW-1:0] line_d, line_q;
  logic [AW-1:0] addr_d, addr_q;
  logic          frame_start;
  logic          rd_vld_d, rd_vld_q;
  logic          dout_valid_d, dout_valid_q;
  logic [DW-1:0] dout_d, dout_q;
  logic [DW-1:0] pix_src;

  // Next-state, counter and address generation for the raster sequence.
  always_comb begin
    state_d     = state_q;
    blank_d     = blank_q;
    pix_d       = pix_q;
    line_d      = line_q;
    addr_d      = addr_q;
    frame_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) frame_start = 1'b1;
      end
      ST_VSYNC: begin
        if (blank_q == VS_LAST) begin
          state_d = ST_VB_PRE;
          blank_d = '0;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      ST_VB_PRE: begin
        if (blank_q == VB_LAST) begin
          state_d = ST_LINE;
          blank_d = '0;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      ST_LINE: begin
        // Address holds at IW*IH-1 after the last pixel instead of wrapping.
        if (!(pix_q == PIX_LAST && line_q == LINE_LAST)) addr_d = addr_q + AW'(1);
        if (pix_q == PIX_LAST) begin
          pix_d = '0;
          if (line_q == LINE_LAST) state_d = ST_VB_POST;
          else                     state_d = ST_HBLANK;
        end else begin
          pix_d = pix_q + PW'(1);
        end
      end
      ST_HBLANK: begin
        if (blank_q == HB_LAST) begin
          state_d = ST_LINE;
          blank_d = '0;
          line_d  = line_q + LW'(1);
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      ST_VB_POST: begin
        if (blank_q == VB_LAST) begin
          if (cont) begin
            frame_start = 1'b1;
          end else begin
            state_d = ST_IDLE;
            blank_d = '0;
          end
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Every frame starts from clean counters and address 0.
    if (frame_start) begin
      state_d = ST_VSYNC;
      blank_d = '0;
      pix_d   = '0;
      line_d  = '0;
      addr_d  = '0;
    end
  end

  // State, counter and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      blank_q <= '0;
      pix_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

`ifdef FRAME_TX_TPG_EN
  logic          pat_sel_d, pat_sel_q;
  logic [DW-1:0] tpg_data;

  // Pattern select is frozen at frame start so a frame is never mixed.
  always_comb begin
    pat_sel_d = pat_sel_q;
    if (frame_start) pat_sel_d = pat_sel;
  end

  // Frozen pattern-select register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pat_sel_q <= 1'b0;
    else        pat_sel_q <= pat_sel_d;
  end

  frame_tx_tpg #(
    .DW(DW),
    .PW(PW),
    .LW(LW)
  ) u_tpg (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .pix_cnt  (pix_q),
    .line_cnt (line_q),
    .pat_data (tpg_data)
  );

  assign pix_src = pat_sel_q ? tpg_data : rd_data;
`else
  logic unused_pat_sel;
  assign unused_pat_sel = pat_sel;
  assign pix_src        = rd_data;
`endif

  // Output pipe: stage 1 qualifies read data, stage 2 registers the pixel.
  always_comb begin
    rd_vld_d     = rd_en;
    dout_valid_d = rd_vld_q;
    dout_d       = dout_q;
    if (rd_vld_q) dout_d = pix_src;
  end

  // Output pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      rd_vld_q     <= rd_vld_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
    end
  end

  assign rd_en      = (state_q == ST_LINE);
  assign rd_addr    = addr_q;
  assign vsync_out  = (state_q == ST_VSYNC);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_VB_POST) && (blank_q == VB_LAST);
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Self-checking bench for frame_stream_tx. Expected raster timing is
// derived per cycle from the frame geometry (offset within the frame
// period), not from the design's state machine.
module tb_frame_stream_tx;

  localparam int DW   = 14;
  localparam int IW   = 4;
  localparam int IH   = 3;
  localparam int AW   = 4;
  localparam int VS   = 2;
  localparam int VB   = 3;
  localparam int HB   = 2;
  localparam int LP   = IW + HB;
  localparam int NPIX = IW * IH;
  localparam int FP   = VS + 2 * VB + IH * IW + (IH - 1) * HB;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          cont;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          pat_sel;
  logic          vsync_out;
  logic          dout_valid;
  logic [DW-1:0] dout;
  logic          busy;
  logic          frame_done;

  logic [DW-1:0] mem [NPIX];

  int checks = 0;
  int errors = 0;

  frame_stream_tx #(
    .DW(DW), .IW(IW), .IH(IH), .AW(AW),
    .VS_LEN(VS), .VB_LEN(VB), .HB_LEN(HB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont       (cont),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pat_sel    (pat_sel),
    .vsync_out  (vsync_out),
    .dout_valid (dout_valid),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous frame-buffer model: data one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en && (rd_addr < AW'(NPIX))) rd_data <= mem[rd_addr];
  end

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < NPIX; i++) mem[i] = rnd ? DW'($urandom) : DW'(i);
  endtask

  // Is frame offset 'off' a pixel slot? Returns its line and column.
  function automatic bit in_line(input int off, output int line, output int pix);
    int lo;
    lo   = off - VS - VB;
    line = 0;
    pix  = 0;
    if (lo < 0) return 1'b0;
    line = lo / LP;
    pix  = lo % LP;
    return (line < IH) && (pix < IW);
  endfunction

  // Starts a frame and compares every output each cycle against the
  // raster expected for 'nframes' back-to-back frames, then idle.
  task automatic run_frames(input string name, input int nframes, input bit cont_in,
                            input int drop_k, input int start_k, input bit use_pat,
                            input bit exp_pat, input int pat_flip_k,
                            output int n_valid, output int n_done, output int last_addr);
    int rel, f, off, e_line, e_pix, v_line, v_pix;
    bit e_busy, e_vs, e_done, e_rd, e_val;
    logic [DW-1:0] e_dout;
    n_valid   = 0;
    n_done    = 0;
    last_addr = -1;
    @(negedge clk);
    cont    = cont_in;
    pat_sel = use_pat;
    start   = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= nframes * FP + 3; k++) begin
      @(negedge clk);
      rel    = k - 1;
      f      = rel / FP;
      off    = rel % FP;
      e_busy = (f < nframes);
      e_vs   = e_busy && (off < VS);
      e_done = e_busy && (off == FP - 1);
      e_rd   = e_busy && in_line(off, e_line, e_pix);
      e_val  = e_busy && in_line(off - 2, v_line, v_pix);
      e_dout = '0;
      if (e_val) e_dout = exp_pat ? DW'(v_line + v_pix) : mem[v_line * IW + v_pix];

      checks++;
      if (vsync_out !== e_vs) begin
        errors++;
        $display("FAIL %s vsync k=%0d got %b want %b", name, k, vsync_out, e_vs);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL %s busy k=%0d got %b want %b", name, k, busy, e_busy);
      end
      checks++;
      if (frame_done !== e_done) begin
        errors++;
        $display("FAIL %s frame_done k=%0d got %b want %b", name, k, frame_done, e_done);
      end
      checks++;
      if (rd_en !== e_rd) begin
        errors++;
        $display("FAIL %s rd_en k=%0d got %b want %b", name, k, rd_en, e_rd);
      end
      if (e_rd) begin
        checks++;
        if (rd_addr !== AW'(e_line * IW + e_pix)) begin
          errors++;
          $display("FAIL %s rd_addr k=%0d got %0d want %0d", name, k, rd_addr, e_line * IW + e_pix);
        end
      end
      checks++;
      if (dout_valid !== e_val) begin
        errors++;
        $display("FAIL %s dout_valid k=%0d got %b want %b", name, k, dout_valid, e_val);
      end
      if (e_val) begin
        checks++;
        if (dout !== e_dout) begin
          errors++;
          $display("FAIL %s dout k=%0d got %0d want %0d", name, k, dout, e_dout);
        end
      end

      if (rd_en === 1'b1) last_addr = int'(rd_addr);
      if (dout_valid === 1'b1) n_valid++;
      if (frame_done === 1'b1) n_done++;

      start = (k == start_k);
      if (k == drop_k)     cont    = 1'b0;
      if (k == pat_flip_k) pat_sel = ~pat_sel;
    end
    start   = 1'b0;
    cont    = 1'b0;
    pat_sel = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    cont    = 1'b0;
    pat_sel = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({vsync_out, dout_valid, dout, rd_en, rd_addr, busy, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_values got %h want 0",
               {vsync_out, dout_valid, dout, rd_en, rd_addr, busy, frame_done});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({vsync_out, busy, rd_en, dout_valid} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 0000", {vsync_out, busy, rd_en, dout_valid});
    end
  endtask

  task automatic test_single_frame();
    int nv, nd, la;
    fill_mem(1'b0);
    run_frames("single", 1, 1'b0, -1, -1, 1'b0, 1'b0, -1, nv, nd, la);
    checks++;
    if (nv != NPIX) begin
      errors++;
      $display("FAIL single_valid_count got %0d want %0d", nv, NPIX);
    end
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL single_done_count got %0d want 1", nd);
    end
    checks++;
    if (la != NPIX - 1) begin
      errors++;
      $display("FAIL single_last_addr got %0d want %0d", la, NPIX - 1);
    end
  endtask

  task automatic test_pixel_latency();
    int nv, nd, la;
    fill_mem(1'b1);
    run_frames("latency", 1, 1'b0, -1, -1, 1'b0, 1'b0, -1, nv, nd, la);
    checks++;
    if (la != NPIX - 1) begin
      errors++;
      $display("FAIL latency_last_addr got %0d want %0d", la, NPIX - 1);
    end
  endtask

  task automatic test_continuous();
    int nv, nd, la;
    fill_mem(1'b1);
    run_frames("continuous", 2, 1'b1, FP + 6, -1, 1'b0, 1'b0, -1, nv, nd, la);
    checks++;
    if (nd != 2) begin
      errors++;
      $display("FAIL cont_done_count got %0d want 2", nd);
    end
    checks++;
    if (nv != 2 * NPIX) begin
      errors++;
      $display("FAIL cont_valid_count got %0d want %0d", nv, 2 * NPIX);
    end
  endtask

  task automatic test_start_while_busy();
    int nv, nd, la;
    fill_mem(1'b0);
    run_frames("start_busy", 1, 1'b0, -1, VS + VB + 2, 1'b0, 1'b0, -1, nv, nd, la);
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL start_busy_done_count got %0d want 1", nd);
    end
  endtask

  task automatic test_reset_mid_frame();
    int p, stop_k, nv, nd, la;
    p      = $urandom_range(0, IW - 1);
    stop_k = VS + VB + LP + p + 1;
    fill_mem(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (stop_k) @(negedge clk);
    checks++;
    if ({rd_en, rd_addr} !== {1'b1, AW'(IW + p)}) begin
      errors++;
      $display("FAIL pre_reset_read got %b/%0d want 1/%0d", rd_en, rd_addr, IW + p);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({vsync_out, dout_valid, dout, rd_en, rd_addr, busy, frame_done} !== '0) begin
      errors++;
      $display("FAIL async_reset got %h want 0",
               {vsync_out, dout_valid, dout, rd_en, rd_addr, busy, frame_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_frames("after_reset", 1, 1'b0, -1, -1, 1'b0, 1'b0, -1, nv, nd, la);
    checks++;
    if (nv != NPIX) begin
      errors++;
      $display("FAIL after_reset_valid_count got %0d want %0d", nv, NPIX);
    end
  endtask

  // With the pattern generator built in, pat_sel=1 selects the pattern and a
  // mid-frame toggle has no effect; without it, pat_sel is ignored.
  task automatic test_pattern();
    int nv, nd, la;
    bit exp_pat;
`ifdef FRAME_TX_TPG_EN
    exp_pat = 1'b1;
`else
    exp_pat = 1'b0;
`endif
    fill_mem(1'b1);
    run_frames("pattern", 1, 1'b0, -1, -1, 1'b1, exp_pat, VS + VB + LP + 2, nv, nd, la);
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL pattern_done_count got %0d want 1", nd);
    end
  endtask

  task automatic test_random();
    int nv, nd, la, nf, drop_k, start_k;
    bit c;
    for (int it = 0; it < 4; it++) begin
      fill_mem(1'b1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      c       = 1'($urandom_range(0, 1));
      nf      = c ? 2 : 1;
      drop_k  = c ? $urandom_range(FP + 1, 2 * FP - 2) : -1;
      start_k = $urandom_range(2, nf * FP - 1);
      run_frames("random", nf, c, drop_k, start_k, 1'b0, 1'b0, -1, nv, nd, la);
      checks++;
      if (nd != nf) begin
        errors++;
        $display("FAIL random_done_count it=%0d got %0d want %0d", it, nd, nf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_pixel_latency();
    test_continuous();
    test_start_while_busy();
    test_reset_mid_frame();
    test_pattern();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
